tst_din_dgen_prbs_mc: RTL

Parametrised multi-lane PRBS test-data generator for the test data-input path. It produces NCH independent lanes of W bits per beat from a runtime-selectable PRBS polynomial (7/15/23/31). Output is a single AXI4-Stream-style beat with backpressure, optional frame marking, and single-bit error injection. It is the stimulus source ahead of the DUT input formatter and the matching checker.

---
 rtl/tst_din_dgen_prbs_mc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tst_din_dgen_prbs_mc.sv
// Multi-lane PRBS test-data generator: NCH independent lanes of W bits per beat,
// runtime-selectable PRBS7/15/23/31, AXI-Stream style output with frame marking and error injection.
module tst_din_dgen_prbs_mc #(
    parameter int          W         = 28,
    parameter int          NCH       = 4,
    parameter logic [31:0] SEED      = 32'h89abcdef,
    parameter int          FRAME_LEN = 1024
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               en,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               err_inj,
    output logic               tvalid_o,
    input  logic               tready_i,
    output logic [NCH*W-1:0]   tdata_o,
    output logic               tlast_o,
    output logic [31:0]        beats_o
);

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS15 = 2'd1,
        PRBS23 = 2'd2,
        PRBS31 = 2'd3
    } prbsMode_e;

    // Lane seed: golden-ratio mix of the base seed, trimmed to the polynomial order, never all-zero.
    function automatic logic [30:0] seedFor(input int c, input logic [1:0] m);
        logic [31:0] mix;
        logic [31:0] msk;
        mix = SEED ^ (32'(c) * 32'h9E3779B9);
        case (prbsMode_e'(m))
            PRBS7:   msk = 32'h0000_007F;
            PRBS15:  msk = 32'h0000_7FFF;
            PRBS23:  msk = 32'h007F_FFFF;
            default: msk = 32'h7FFF_FFFF;
        endcase
        mix = mix & msk;
        if (mix == 32'd0) mix = 32'd1;
        return mix[30:0];
    endfunction

    // Window bit i holds x[n+i]; each step appends x[n+N] = x[n] ^ x[n+N-M] at bit N-1.
    function automatic logic [W+30:0] stepLane(input logic [30:0] sIn, input logic [1:0] m);
        logic [30:0]  s;
        logic [W-1:0] b;
        logic         nb;
        s = sIn;
        b = '0;
        for (int j = 0; j < W; j++) begin
            case (prbsMode_e'(m))
                PRBS7, PRBS15: nb = s[0] ^ s[1];
                PRBS23:        nb = s[0] ^ s[5];
                default:       nb = s[0] ^ s[3];
            endcase
            b[j] = nb;
            s = s >> 1;
            case (prbsMode_e'(m))
                PRBS7:   s[6]  = nb;
                PRBS15:  s[14] = nb;
                PRBS23:  s[22] = nb;
                default: s[30] = nb;
            endcase
        end
        return {s, b};
    endfunction

    logic [1:0]       mode_q;
    logic [30:0]      state_q [NCH];
    logic [30:0]      state_d [NCH];
    logic [NCH*W-1:0] beat_d;
    logic [NCH*W-1:0] tdata_q;
    logic [NCH*W-1:0] tdata_d;
    logic             tvalid_q;
    logic             tlast_q;
    logic             tlast_d;
    logic [31:0]      beats_q;
    logic [31:0]      frame_q;
    logic [31:0]      frame_d;
    logic [31:0]      loadIdx;
    logic             errPend_q;
    logic             errNow;
    logic             accept;
    logic             load;

    always_comb begin
        beat_d = '0;
        for (int c = 0; c < NCH; c++) begin
            {state_d[c], beat_d[c*W +: W]} = stepLane(state_q[c], mode_q);
        end
    end

    // The frame index of a newly loaded beat accounts for the beat leaving in the same cycle.
    always_comb begin
        accept  = tvalid_q && tready_i;
        load    = en && (!tvalid_q || tready_i) && !start;
        errNow  = errPend_q || err_inj;
        frame_d = (frame_q == 32'(FRAME_LEN - 1)) ? 32'd0 : frame_q + 32'd1;
        loadIdx = accept ? frame_d : frame_q;
        tlast_d = (loadIdx == 32'(FRAME_LEN - 1));
        tdata_d = beat_d;
        tdata_d[0] = beat_d[0] ^ errNow;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_q    <= mode;
            for (int c = 0; c < NCH; c++) state_q[c] <= seedFor(c, mode);
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            beats_q   <= 32'd0;
            frame_q   <= 32'd0;
            errPend_q <= 1'b0;
        end else if (start) begin
            mode_q    <= mode;
            for (int c = 0; c < NCH; c++) state_q[c] <= seedFor(c, mode);
            tvalid_q  <= 1'b0;
            beats_q   <= 32'd0;
            frame_q   <= 32'd0;
            errPend_q <= 1'b0;
        end else begin
            if (accept) begin
                beats_q <= beats_q + 32'd1;
                frame_q <= frame_d;
            end
            if (load) begin
                for (int c = 0; c < NCH; c++) state_q[c] <= state_d[c];
                tdata_q   <= tdata_d;
                tlast_q   <= tlast_d;
                tvalid_q  <= 1'b1;
                errPend_q <= 1'b0;
            end else begin
                errPend_q <= errNow;
                if (!en && tready_i) tvalid_q <= 1'b0;
            end
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;
    assign tlast_o  = tlast_q;
    assign beats_o  = beats_q;

endmodule
